// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_DATA_W          : byte width on the serial side
//   UART_FIFO_DEPTH_LOG2 : default log2 depth of the transmit byte queue
//   uart_tx_state_e      : issue FSM state encoding
package uart_pkg;

    localparam int unsigned UART_DATA_W          = 8;
    localparam int unsigned UART_FIFO_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with registered level/full/empty and a sticky overflow flag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_i, dat_i  : push strobe and data; a push while full is dropped and sets ovf_o
//   rd_i         : pop strobe; ignored while empty
//   rd_dat_o     : head of queue (valid while empty_o is low)
//   full_o, empty_o, level_o : registered occupancy
//   ovf_o, ovf_clr_i         : sticky drop flag and its clear (a drop wins over clear)
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [DATA_W-1:0]     dat_i,
    input  logic                  rd_i,
    output logic [DATA_W-1:0]     rd_dat_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [LEVEL_W-1:0]    LEVEL_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0]    LEVEL_MAX = LEVEL_W'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop;

    // Gating uses the registered flags, so a same-cycle pop never frees room for a push.
    assign push = wr_i && !full_q;
    assign pop  = rd_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (wr_i && full_q) begin
            ovf_d = 1'b1;
        end

        full_d  = (level_d == LEVEL_MAX);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue and issue controller in front of the UART transmitter.
//   sys_clk_i, sys_rst_i      : system clock, synchronous active-high reset
//   wr_i, dat_i               : producer push interface
//   full_o, empty_o, level_o  : queue occupancy
//   ovf_o, ovf_clr_i          : sticky dropped-push flag and clear
//   uart_wr_o, uart_dat_o     : one-cycle write pulse and held byte to the transmitter
//   uart_busy_i               : transmitter busy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  wr_i,
    input  logic [DATA_W-1:0]     dat_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    output logic                  uart_wr_o,
    output logic [DATA_W-1:0]     uart_dat_o,
    input  logic                  uart_busy_i
);

    uart_tx_state_e    state_q, state_d;
    logic              uart_wr_q, uart_wr_d;
    logic [DATA_W-1:0] uart_dat_q, uart_dat_d;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              empty;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk_i      (sys_clk_i),
        .rst_i      (sys_rst_i),
        .wr_i       (wr_i),
        .dat_i      (dat_i),
        .rd_i       (pop),
        .rd_dat_o   (head),
        .full_o     (full_o),
        .empty_o    (empty),
        .level_o    (level_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always_comb begin
        state_d    = state_q;
        uart_wr_d  = 1'b0;
        uart_dat_d = uart_dat_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && !uart_busy_i) begin
                    uart_dat_d = head;
                    uart_wr_d  = 1'b1;
                    pop        = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            // Ends the pulse and skips the cycle before the transmitter raises busy.
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                if (!uart_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= ST_IDLE;
            uart_wr_q  <= 1'b0;
            uart_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            uart_wr_q  <= uart_wr_d;
            uart_dat_q <= uart_dat_d;
        end
    end

    assign empty_o    = empty;
    assign uart_wr_o  = uart_wr_q;
    assign uart_dat_o = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       sys_clk;
    logic       sys_rst;
    logic       wr;
    logic [7:0] dat;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       ovf_clr;
    logic       uart_wr;
    logic [7:0] uart_dat;
    logic       busy;

    // Behavioural transmitter: busy rises the cycle after it latches a write pulse.
    logic       tx_en;
    logic       busy_force;
    int         tx_len;
    int         tx_cnt;

    int         checks;
    int         failures;
    int         pulses;
    int         double_high;
    int         wr_while_busy;
    logic       wr_prev;
    logic [7:0] log_q[$];

    uart_tx_fifo dut (
        .sys_clk_i   (sys_clk),
        .sys_rst_i   (sys_rst),
        .wr_i        (wr),
        .dat_i       (dat),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .uart_wr_o   (uart_wr),
        .uart_dat_o  (uart_dat),
        .uart_busy_i (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always_comb busy = tx_en ? (tx_cnt != 0) : busy_force;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_cnt <= 0;
        end else if (tx_en && uart_wr) begin
            tx_cnt <= tx_len;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
    end

    // Pulse monitor sampled mid-cycle.
    initial begin
        pulses        = 0;
        double_high   = 0;
        wr_while_busy = 0;
        wr_prev       = 1'b0;
    end
    always @(negedge sys_clk) begin
        if (uart_wr === 1'b1) begin
            log_q.push_back(uart_dat);
            pulses = pulses + 1;
            if (wr_prev) double_high = double_high + 1;
            if (tx_en && busy) wr_while_busy = wr_while_busy + 1;
        end
        wr_prev = (uart_wr === 1'b1);
    end

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] dat;
        logic       busy;
        logic       clr;
        logic [4:0] e_level;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_wr;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_level, input logic e_full,
                           input logic e_empty, input logic e_ovf);
        chk({tag, ".level"}, 32'(level), 32'(e_level));
        chk({tag, ".full"}, 32'(full), 32'(e_full));
        chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    endtask

    task automatic wait_pulses(input int target, input int limit);
        int k;
        k = 0;
        while (pulses < target && k < limit) begin
            step();
            k++;
        end
        chk("pulse_wait", 32'(pulses), 32'(target));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 3000) begin
            step();
            k++;
        end
        chk("busy_release", 32'(k < 3000), 32'd1);
        repeat (4) step();
    endtask

    task automatic push(input logic [7:0] b);
        wr  = 1'b1;
        dat = b;
        step();
        wr  = 1'b0;
    endtask

    initial begin
        int p0;
        int wb0;
        checks     = 0;
        failures   = 0;
        sys_rst    = 1'b1;
        wr         = 1'b0;
        dat        = 8'h00;
        ovf_clr    = 1'b0;
        tx_en      = 1'b0;
        busy_force = 1'b0;
        tx_len     = 910;

        //          rst  wr   dat    busy clr  level full empty ovf  wr   dat
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[9]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[10] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        // Push coincides with an issue pop: level holds at 5.
        vecs[11] = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 16; i++) begin
            sys_rst    = vecs[i].rst;
            wr         = vecs[i].wr;
            dat        = vecs[i].dat;
            busy_force = vecs[i].busy;
            ovf_clr    = vecs[i].clr;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_level, vecs[i].e_full, vecs[i].e_empty,
                    vecs[i].e_ovf);
            chk($sformatf("vec%0d.uart_wr", i), 32'(uart_wr), 32'(vecs[i].e_wr));
            chk($sformatf("vec%0d.uart_dat", i), 32'(uart_dat), 32'(vecs[i].e_dat));
        end
        sys_rst    = 1'b0;
        wr         = 1'b0;
        busy_force = 1'b0;

        // Idle for 100 cycles: no pulses.
        p0 = pulses;
        repeat (100) step();
        chk("idle.pulses", 32'(pulses), 32'(p0));
        chk_all("idle", 5'd0, 1'b0, 1'b1, 1'b0);

        // Three bytes back-to-back through the transmitter model.
        log_q.delete();
        p0     = pulses;
        wb0    = wr_while_busy;
        tx_len = 910;
        tx_en  = 1'b1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        wait_pulses(p0 + 3, 5000);
        chk("b2b.byte0", 32'(log_q.size() > 0 ? log_q[0] : 8'hEE), 32'h41);
        chk("b2b.byte1", 32'(log_q.size() > 1 ? log_q[1] : 8'hEE), 32'h42);
        chk("b2b.byte2", 32'(log_q.size() > 2 ? log_q[2] : 8'hEE), 32'h43);
        chk("b2b.wr_while_busy", 32'(wr_while_busy), 32'(wb0));
        chk("b2b.pulse_width", 32'(double_high), 32'd0);
        wait_idle();

        // Fill past full with busy held; 17th push coincides with clear, set wins.
        tx_en      = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr      = 1'b1;
            dat     = 8'(i);
            ovf_clr = (i == 16);
            step();
            if (i == 15) chk_all("fill16", 5'd16, 1'b1, 1'b0, 1'b0);
        end
        wr      = 1'b0;
        ovf_clr = 1'b0;
        chk_all("fill17", 5'd16, 1'b1, 1'b0, 1'b1);
        log_q.delete();
        p0     = pulses;
        tx_len = 40;
        tx_en  = 1'b1;
        wait_pulses(p0 + 16, 3000);
        wait_idle();
        chk("drain.exact_count", 32'(pulses), 32'(p0 + 16));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain.byte%0d", i), 32'(log_q.size() > i ? log_q[i] : 8'hEE),
                32'(i));
        end
        chk_all("drained", 5'd0, 1'b0, 1'b1, 1'b1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Push at full coinciding with a pop: push dropped, level 15.
        tx_en      = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk_all("refill", 5'd16, 1'b1, 1'b0, 1'b0);
        busy_force = 1'b0;
        wr         = 1'b1;
        dat        = 8'hEE;
        step();
        wr         = 1'b0;
        busy_force = 1'b1;
        chk_all("full_pop", 5'd15, 1'b0, 1'b0, 1'b1);
        chk("full_pop.uart_wr", 32'(uart_wr), 32'd1);
        chk("full_pop.uart_dat", 32'(uart_dat), 32'h80);
        step();

        // Reset during GUARD with three bytes queued.
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("rst1.ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        busy_force = 1'b0;
        step();
        chk("guard.level", 32'(level), 32'd3);
        chk("guard.uart_dat", 32'(uart_dat), 32'hC0);
        busy_force = 1'b1;
        step();
        chk("guard.uart_wr", 32'(uart_wr), 32'd0);
        sys_rst = 1'b1;
        step();
        sys_rst    = 1'b0;
        busy_force = 1'b0;
        chk_all("rst2", 5'd0, 1'b0, 1'b1, 1'b0);
        chk("rst2.uart_wr", 32'(uart_wr), 32'd0);
        chk("rst2.uart_dat", 32'(uart_dat), 32'h00);
        p0 = pulses;
        repeat (20) step();
        chk("rst2.no_pulse", 32'(pulses), 32'(p0));
        push(8'h5A);
        step();
        chk("post_rst.uart_wr", 32'(uart_wr), 32'd1);
        chk("post_rst.uart_dat", 32'(uart_dat), 32'h5A);
        chk("post_rst.level", 32'(level), 32'd0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte queue and issue controller directly upstream of the 115200-baud UART transmitter.
- Producers (event formatter, command responder) push bytes at system-clock rate without watching the serial line.
- This block buffers them and hands them to the transmitter one at a time via its uart_wr_i / uart_dat_i / uart_busy handshake.
- Prevents byte loss when bursts arrive while a character is still shifting out.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 bytes (16).
- DATA_W, 8: byte width. Fixed at 8; present for package consistency only.

Ports:
- sys_clk_i  in  1  system clock, 9.6 MHz
- sys_rst_i  in  1  synchronous, active-high reset
- wr_i  in  1  push strobe; one byte per cycle when high
- dat_i  in  8  byte to push
- full_o  out  1  FIFO holds 2**DEPTH_LOG2 bytes
- empty_o  out  1  FIFO holds 0 bytes
- level_o  out  DEPTH_LOG2+1  current byte count
- ovf_o  out  1  sticky: a push was dropped
- ovf_clr_i  in  1  clears ovf_o
- uart_wr_o  out  1  to transmitter uart_wr_i; single-cycle pulse
- uart_dat_o  out  8  to transmitter uart_dat_i; stable from pulse until next issue
- uart_busy_i  in  1  from transmitter uart_busy

Behaviour:
- Reset (sys_rst_i sampled high at a sys_clk_i edge):
  - rd/wr pointers and level cleared; level_o=0, empty_o=1, full_o=0.
  - ovf_o=0, uart_wr_o=0, uart_dat_o=8'h00, state=IDLE.
  - Reset mid-transfer discards all queued bytes. The transmitter is reset by the same sys_rst_i, so no partial handshake survives.
- Push:
  - wr_i high and full_o low: dat_i is written at wr pointer, which increments modulo depth.
  - wr_i high and full_o high: byte dropped, pointers unchanged, ovf_o set.
  - full_o is the registered state at the edge. A same-cycle pop does NOT make room for the push.
- ovf_o:
  - Cleared by ovf_clr_i.
  - If ovf_clr_i and a dropped push coincide, set wins.
- Pop: only by the issue FSM (below). Reads the head and increments rd pointer modulo depth.
- Simultaneous push + pop, FIFO neither empty nor full: both happen; level unchanged.
- level_o, full_o, empty_o: registered, updated in the same edge as the push/pop.
- Pointers: DEPTH_LOG2 bits, wrap naturally. Full/empty are derived from level, not pointer compare.
- Issue FSM, 3 states:
  - IDLE: if empty_o=0 and uart_busy_i=0 at an edge: uart_dat_o <= head byte, pop, uart_wr_o <= 1, go ISSUE. Otherwise stay.
  - ISSUE: uart_wr_o <= 0, go GUARD. Guarantees a one-cycle pulse and covers the one-cycle delay before the transmitter raises busy.
  - GUARD: when uart_busy_i=0, go IDLE; else stay.
- Latency: byte pushed into an empty FIFO with the transmitter idle at edge N gives uart_wr_o high during cycle N+1 → N+2. The transmitter latches at edge N+2.
- Ordering: strict FIFO order; no byte issued twice or skipped.
- Back-to-back: next byte issued the first edge after busy falls while in IDLE. Pacing is set solely by the transmitter's busy; this block adds no baud timing.
- uart_dat_o holds its value outside issue edges.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - UART_FIFO_DEPTH_LOG2 = 4
  - FSM state encodings: ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_GUARD = 2'd2
- One sub-module, sync_fifo:
  - Parameterised storage, pointers, level, full/empty, overflow flag.
  - Reusable by the planned UART receive path.
- uart_tx_fifo instantiates sync_fifo and contains the issue FSM.

Test Plan:
- Reset then idle, busy=0 → level_o=0, empty_o=1, full_o=0, ovf_o=0, uart_wr_o never asserts over 100 cycles.
- Push 8'hA5 at edge N, busy model idle → uart_wr_o high exactly one cycle (N+1 → N+2), uart_dat_o=8'hA5, level_o returns to 0.
- Push 8'h41,8'h42,8'h43 back-to-back with a behavioural transmitter (busy high 1 cycle after wr, ~910 cycles) → three pulses in order 41,42,43; each pulse only after busy low; no pulse while busy=1.
- Hold busy=1, push 17 bytes 8'h00..8'h10 → level_o=16, full_o=1, ovf_o=1, byte 8'h10 dropped. Release busy → 00..0F emitted in order. ovf_clr_i pulse → ovf_o=0.
- FIFO at level 5 while busy=0: push coincides with an issue pop → level_o stays 5. Push at full coinciding with pop → push dropped, ovf_o=1, level_o=15.
- Assert sys_rst_i during GUARD with level 3 → next cycle level_o=0, uart_wr_o=0, uart_dat_o=8'h00, state IDLE. No further pulses until a new push.
